// File: rtl/spmv_val_rd_arbiter.sv
// spmv_val_rd_arbiter
//   Read-only AXI arbiter sharing the single HBM Val port among
//   CONF_NUM_KERNEL spmv_calc_kernel Val masters.
//   - AR: round-robin pick among requesting kernels, request latched and
//     re-issued on m_ar* from registers, at most one AR per two cycles.
//   - Grant order is kept in an in-order ID FIFO (OST_DEPTH deep); the FIFO
//     head selects which kernel sees the R channel (combinational steering).
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   s_ar* / s_arvalid/ready   per-kernel AR channels, kernel i at slice i
//   s_r*  / s_rvalid/ready    per-kernel R channels (data/resp broadcast)
//   m_ar* / m_arvalid/ready   HBM AR channel
//   m_r*  / m_rvalid/ready    HBM R channel
//   ost_cnt                   bursts issued and not yet completed
//   busy                      outstanding bursts or an AR being issued
//
// Optional build macro SPMV_VAL_ARB_PERF_EN adds:
//   perf_grant_cnt            per-kernel saturating AR grant counters
//   perf_stall_cnt            saturating count of cycles a request is
//                             pending while the order FIFO is full
module spmv_val_rd_arbiter #(
   parameter int unsigned CONF_NUM_KERNEL = 4,
   parameter int unsigned ADDR_W          = 48,
   parameter int unsigned DATA_W          = 256,
   parameter int unsigned OST_DEPTH       = 16
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [CONF_NUM_KERNEL*ADDR_W-1:0] s_araddr,
   input  logic [CONF_NUM_KERNEL*8-1:0]      s_arlen,
   input  logic [CONF_NUM_KERNEL*3-1:0]      s_arsize,
   input  logic [CONF_NUM_KERNEL*2-1:0]      s_arburst,
   input  logic [CONF_NUM_KERNEL-1:0]        s_arvalid,
   output logic [CONF_NUM_KERNEL-1:0]        s_arready,
   output logic [CONF_NUM_KERNEL*DATA_W-1:0] s_rdata,
   output logic [CONF_NUM_KERNEL*2-1:0]      s_rresp,
   output logic [CONF_NUM_KERNEL-1:0]        s_rlast,
   output logic [CONF_NUM_KERNEL-1:0]        s_rvalid,
   input  logic [CONF_NUM_KERNEL-1:0]        s_rready,
   output logic [ADDR_W-1:0]                 m_araddr,
   output logic [7:0]                        m_arlen,
   output logic [2:0]                        m_arsize,
   output logic [1:0]                        m_arburst,
   output logic                              m_arvalid,
   input  logic                              m_arready,
   input  logic [DATA_W-1:0]                 m_rdata,
   input  logic [1:0]                        m_rresp,
   input  logic                              m_rlast,
   input  logic                              m_rvalid,
   output logic                              m_rready,
   output logic [$clog2(OST_DEPTH):0]        ost_cnt,
   output logic                              busy
`ifdef SPMV_VAL_ARB_PERF_EN
   ,
   output logic [CONF_NUM_KERNEL*32-1:0]     perf_grant_cnt,
   output logic [31:0]                       perf_stall_cnt
`endif
);

   localparam int unsigned IDX_W = (CONF_NUM_KERNEL > 1) ? $clog2(CONF_NUM_KERNEL) : 1;
   localparam int unsigned PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(OST_DEPTH) + 1;

   typedef enum logic [0:0] {
      IDLE,
      ISSUE
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] ar_idx;
   logic [IDX_W-1:0] win_idx;
   logic             win_found;
   logic             ost_full;
   logic             fifo_empty;
   logic             ar_hs;
   logic             r_pop;

   logic [IDX_W-1:0] ord_mem [OST_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [IDX_W-1:0] head_idx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OST_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign ost_full   = (ost_cnt == CNT_W'(OST_DEPTH));
   assign fifo_empty = (ost_cnt == '0);
   assign ar_hs      = m_arvalid & m_arready;
   assign head_idx   = ord_mem[rd_ptr];
   assign busy       = !fifo_empty || (state != IDLE);

   // Round-robin scan: first requester at or above rr_ptr, wrapping.
   always_comb begin
      int unsigned      cand;
      logic [IDX_W-1:0] cand_idx;
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned off = 0; off < CONF_NUM_KERNEL; off++) begin
         cand = 32'(rr_ptr) + off;
         if (cand >= CONF_NUM_KERNEL) cand = cand - CONF_NUM_KERNEL;
         cand_idx = cand[IDX_W-1:0];
         if (!win_found && s_arvalid[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // AR FSM: latch winner in IDLE, present it from registers in ISSUE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         ar_idx    <= '0;
         m_araddr  <= '0;
         m_arlen   <= '0;
         m_arsize  <= '0;
         m_arburst <= '0;
         m_arvalid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found && !ost_full) begin
                  state     <= ISSUE;
                  ar_idx    <= win_idx;
                  m_araddr  <= s_araddr[win_idx*ADDR_W +: ADDR_W];
                  m_arlen   <= s_arlen[win_idx*8 +: 8];
                  m_arsize  <= s_arsize[win_idx*3 +: 3];
                  m_arburst <= s_arburst[win_idx*2 +: 2];
                  m_arvalid <= 1'b1;
               end
            end
            ISSUE: begin
               if (m_arready) begin
                  state     <= IDLE;
                  m_arvalid <= 1'b0;
                  rr_ptr    <= (ar_idx == IDX_W'(CONF_NUM_KERNEL - 1)) ? '0 : ar_idx + IDX_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Kernel AR handshake completes in the same cycle as the HBM handshake.
   always_comb begin
      s_arready = '0;
      if (state == ISSUE && m_arready) s_arready[ar_idx] = 1'b1;
   end

   // Order FIFO storage (no reset needed: validity is tracked by ost_cnt).
   always_ff @(posedge clk) begin
      if (ar_hs) ord_mem[wr_ptr] <= ar_idx;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ost_cnt <= '0;
      end else begin
         if (ar_hs) wr_ptr <= ptr_inc(wr_ptr);
         if (r_pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({ar_hs, r_pop})
            2'b10:   ost_cnt <= ost_cnt + CNT_W'(1);
            2'b01:   ost_cnt <= ost_cnt - CNT_W'(1);
            default: ost_cnt <= ost_cnt;
         endcase
      end
   end

   // R steering: only the FIFO head kernel sees the HBM R channel.
   always_comb begin
      s_rvalid = '0;
      s_rlast  = '0;
      m_rready = 1'b0;
      if (!fifo_empty) begin
         s_rvalid[head_idx] = m_rvalid;
         s_rlast[head_idx]  = m_rlast;
         m_rready           = s_rready[head_idx];
      end
   end

   assign r_pop   = m_rvalid & m_rready & m_rlast;
   assign s_rdata = {CONF_NUM_KERNEL{m_rdata}};
   assign s_rresp = {CONF_NUM_KERNEL{m_rresp}};

`ifdef SPMV_VAL_ARB_PERF_EN
   logic [31:0] grant_cnt [CONF_NUM_KERNEL];
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned k = 0; k < CONF_NUM_KERNEL; k++) grant_cnt[k] <= '0;
         stall_cnt <= '0;
      end else begin
         for (int unsigned k = 0; k < CONF_NUM_KERNEL; k++) begin
            if (ar_hs && ar_idx == IDX_W'(k) && grant_cnt[k] != '1)
               grant_cnt[k] <= grant_cnt[k] + 32'd1;
         end
         if ((|s_arvalid) && ost_full && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   always_comb begin
      perf_grant_cnt = '0;
      for (int unsigned k = 0; k < CONF_NUM_KERNEL; k++)
         perf_grant_cnt[k*32 +: 32] = grant_cnt[k];
   end

   assign perf_stall_cnt = stall_cnt;
`endif

endmodule
